// File: rtl/rotation_parser.sv
// Parses an ASCII stream of rotation records ("L68\n", "R48\r\n", ...) into
// signed 32-bit rotations, one record per out_valid/out_ready transfer.
module rotation_parser (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_n,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        err,
    output logic [15:0] rec_count
);

    // Handshakes: a byte moves when in_valid & in_ready at a rising edge; a
    // record moves when out_valid & out_ready. out_n is held while stalled.

    typedef enum logic [1:0] {
        S_DIR   = 2'd0,
        S_DIGIT = 2'd1,
        S_EMIT  = 2'd2
    } state_t;

    localparam logic [7:0]  CH_L     = 8'h4C;
    localparam logic [7:0]  CH_R     = 8'h52;
    localparam logic [7:0]  CH_CR    = 8'h0D;
    localparam logic [7:0]  CH_LF    = 8'h0A;
    localparam logic [7:0]  CH_SP    = 8'h20;
    localparam logic [7:0]  CH_0     = 8'h30;
    localparam logic [7:0]  CH_9     = 8'h39;
    localparam logic [35:0] MAG_MAX  = 36'd2147483647;

    state_t      state_q, state_d;
    logic [31:0] mag_q, mag_d;
    logic        neg_q, neg_d;
    logic        dig_q, dig_d;
    logic [31:0] out_n_q, out_n_d;
    logic        err_q, err_d;
    logic [15:0] rec_q, rec_d;
    logic        run_q;

    logic        accept;
    logic        is_digit;
    logic [35:0] mag_ext;

    always_comb begin
        in_ready = run_q && (state_q != S_EMIT);
        accept   = in_valid && in_ready;
        is_digit = (in_data >= CH_0) && (in_data <= CH_9);
        // Wide enough that max*10+9 cannot wrap before the saturation compare.
        mag_ext  = ({4'd0, mag_q} * 36'd10) + {32'd0, in_data[3:0]};
    end

    always_comb begin
        state_d = state_q;
        mag_d   = mag_q;
        neg_d   = neg_q;
        dig_d   = dig_q;
        out_n_d = out_n_q;
        err_d   = err_q;
        rec_d   = rec_q;

        case (state_q)
            S_DIR: begin
                if (accept) begin
                    if ((in_data == CH_L) || (in_data == CH_R)) begin
                        neg_d   = (in_data == CH_L);
                        mag_d   = 32'd0;
                        dig_d   = 1'b0;
                        state_d = S_DIGIT;
                    end else if ((in_data != CH_CR) && (in_data != CH_LF) &&
                                 (in_data != CH_SP)) begin
                        err_d = 1'b1;
                    end
                end
            end

            S_DIGIT: begin
                if (accept) begin
                    if (is_digit) begin
                        dig_d = 1'b1;
                        if (mag_ext > MAG_MAX) begin
                            mag_d = MAG_MAX[31:0];
                            err_d = 1'b1;
                        end else begin
                            mag_d = mag_ext[31:0];
                        end
                    end else if (in_data == CH_CR) begin
                        state_d = S_DIGIT;
                    end else if ((in_data == CH_LF) && dig_q) begin
                        // Two's-complement negate; zero stays zero for "L0".
                        out_n_d = neg_q ? (~mag_q + 32'd1) : mag_q;
                        state_d = S_EMIT;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_DIR;
                    end
                end
            end

            S_EMIT: begin
                if (out_ready) begin
                    rec_d   = rec_q + 16'd1;
                    state_d = S_DIR;
                end
            end

            default: begin
                state_d = S_DIR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_DIR;
            mag_q   <= 32'd0;
            neg_q   <= 1'b0;
            dig_q   <= 1'b0;
            out_n_q <= 32'd0;
            err_q   <= 1'b0;
            rec_q   <= 16'd0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            neg_q   <= neg_d;
            dig_q   <= dig_d;
            out_n_q <= out_n_d;
            err_q   <= err_d;
            rec_q   <= rec_d;
            run_q   <= 1'b1;
        end
    end

    assign out_n     = out_n_q;
    assign out_valid = (state_q == S_EMIT);
    assign err       = err_q;
    assign rec_count = rec_q;

endmodule

// File: tb/tb_rotation_parser.sv
// Bench for rotation_parser: directed records plus randomly composed records
// whose expected rotation is computed from the decimal text and clamped.
module tb_rotation_parser;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] out_n;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        err;
    logic [15:0] rec_count;

    rotation_parser dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_n     (out_n),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err),
        .rec_count (rec_count)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    int          exp_rec = 0;
    logic        exp_err = 1'b0;
    int          rdy_mode = 1;   // 0: hold low, 1: hold high, 2: random
    logic        stall_prev = 1'b0;
    logic [31:0] n_prev = 32'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, got, got, exp, exp);
        end
    endtask

    // Drives out_ready and checks every output transfer against exp_q.
    always @(negedge clk) begin
        if (rdy_mode == 0)      out_ready = 1'b0;
        else if (rdy_mode == 1) out_ready = 1'b1;
        else                    out_ready = ($urandom_range(0, 9) < 7);
        if (out_valid && stall_prev) check("out_n_hold", out_n, n_prev);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("spurious_emit", {31'd0, out_valid}, 32'd0);
            else                   check("out_n", out_n, exp_q.pop_front());
            check("rec_count_at_xfer", {16'd0, rec_count}, exp_rec);
            exp_rec = (exp_rec + 1) % 65536;
        end
        stall_prev = out_valid && !out_ready;
        n_prev     = out_n;
    end

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        in_data  = b;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 300) begin
                check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        exp_rec  = 0;
        exp_err  = 1'b0;
        #2;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_n", out_n, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_rec_count", {16'd0, rec_count}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_after_rst", {31'd0, in_ready}, 32'd1);
    endtask

    // Builds one random record; the expected value comes from the decimal
    // text evaluated exactly and then clamped to the 31-bit magnitude limit.
    task automatic random_record();
        int          kind;
        logic [7:0]  b;
        logic [7:0]  bytes[$];
        longint      v;
        longint      sv;
        logic        neg;
        int          nd;
        logic [7:0]  ws[3];
        ws[0] = 8'h0D; ws[1] = 8'h0A; ws[2] = 8'h20;
        kind = $urandom_range(0, 9);
        neg  = $urandom_range(0, 1);
        repeat ($urandom_range(0, 2)) bytes.push_back(ws[$urandom_range(0, 2)]);
        if (kind <= 5 || kind == 9) begin
            bytes.push_back(neg ? 8'h4C : 8'h52);
            nd = (kind == 9) ? $urandom_range(9, 12) : $urandom_range(1, 6);
            v = 0;
            for (int i = 0; i < nd; i++) begin
                b = 8'($urandom_range(0, 9));
                v = v * 10 + longint'(b);
                bytes.push_back(8'h30 + b);
                if ($urandom_range(0, 9) == 0) bytes.push_back(8'h0D);
            end
            if (v > 64'sd2147483647) begin
                v = 64'sd2147483647;
                exp_err = 1'b1;
            end
            sv = neg ? -v : v;
            if ($urandom_range(0, 1) == 1) bytes.push_back(8'h0D);
            bytes.push_back(8'h0A);
            exp_q.push_back(sv[31:0]);
        end else if (kind == 6) begin
            do b = 8'($urandom_range(0, 255));
            while (b == 8'h4C || b == 8'h52 || b == 8'h0D || b == 8'h0A || b == 8'h20);
            bytes.push_back(b);
            exp_err = 1'b1;
        end else if (kind == 7) begin
            bytes.push_back(neg ? 8'h4C : 8'h52);
            bytes.push_back(8'h0A);
            exp_err = 1'b1;
        end else begin
            bytes.push_back(neg ? 8'h4C : 8'h52);
            repeat ($urandom_range(0, 3)) bytes.push_back(8'h30 + 8'($urandom_range(0, 9)));
            do b = 8'($urandom_range(0, 255));
            while ((b >= 8'h30 && b <= 8'h39) || b == 8'h0D || b == 8'h0A);
            bytes.push_back(b);
            exp_err = 1'b1;
        end
        foreach (bytes[i]) send_byte(bytes[i]);
        check("err_after_record", {31'd0, err}, {31'd0, exp_err});
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        do_reset();
        rdy_mode = 1;

        exp_q.push_back(32'd48);
        send_str("R48\n");
        check("r48_latency_valid", {31'd0, out_valid}, 32'd1);
        check("r48_latency_n", out_n, 32'd48);
        @(posedge clk);
        #1;
        check("r48_single_pulse", {31'd0, out_valid}, 32'd0);
        wait_drain();
        check("r48_rec_count", {16'd0, rec_count}, 32'd1);
        check("r48_err", {31'd0, err}, 32'd0);

        exp_q.push_back(32'hFFFF_FFBC);
        send_str("L68\r\n");
        wait_drain();
        check("l68_err", {31'd0, err}, 32'd0);
        check("l68_rec_count", {16'd0, rec_count}, exp_rec);

        rdy_mode = 0;
        exp_q.push_back(-32'sd5);
        send_str("L5\n");
        for (int i = 0; i < 3; i++) begin
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            check("stall_n", out_n, -32'sd5);
            @(posedge clk);
            #1;
        end
        rdy_mode = 1;
        check("stall_valid_4th", {31'd0, out_valid}, 32'd1);
        check("stall_in_ready_4th", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        check("stall_released", {31'd0, out_valid}, 32'd0);
        check("stall_rec_count", {16'd0, rec_count}, 32'd3);

        exp_q.push_back(32'd0);
        send_str("L0\n");
        exp_q.push_back(32'd0);
        send_str("R0\n");
        wait_drain();
        check("zero_err", {31'd0, err}, 32'd0);

        do_reset();
        send_str("X");
        check("junk_err", {31'd0, err}, 32'd1);
        exp_q.push_back(32'd7);
        send_str("R7\n");
        send_str("R\n");
        wait_drain();
        check("junk_err_sticky", {31'd0, err}, 32'd1);
        check("junk_rec_count", {16'd0, rec_count}, 32'd1);

        do_reset();
        exp_q.push_back(32'd2147483647);
        send_str("R99999999999\n");
        wait_drain();
        check("sat_pos_err", {31'd0, err}, 32'd1);
        exp_q.push_back(-32'sd2147483647);
        send_str("L99999999999\n");
        wait_drain();

        do_reset();
        send_str("R12");
        do_reset();
        exp_q.push_back(-32'sd3);
        send_str("L3\n");
        wait_drain();
        check("midrec_rst_rec_count", {16'd0, rec_count}, 32'd1);
        check("midrec_rst_err", {31'd0, err}, 32'd0);

        rdy_mode = 0;
        send_str("R9\n");
        check("emit_before_rst", {31'd0, out_valid}, 32'd1);
        do_reset();
        rdy_mode = 1;
        repeat (3) @(posedge clk);
        #1;
        check("emit_rst_dropped", {16'd0, rec_count}, 32'd0);
        check("emit_rst_valid", {31'd0, out_valid}, 32'd0);

        do_reset();
        rdy_mode = 2;
        for (int r = 0; r < 150; r++) random_record();
        wait_drain();
        check("final_rec_count", {16'd0, rec_count}, exp_rec);
        check("final_err", {31'd0, err}, {31'd0, exp_err});

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/rotation_parser.md
ROTATION_PARSER -- requirements
Module: rotation_parser

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all state SHALL update on the rising edge of clk.
REQ-002 clk  input  1  system clock.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 in_data  input  8  ASCII byte of the rotation text stream.
REQ-005 in_valid  input  1  in_data is valid this cycle.
REQ-006 in_ready  output  1  the block accepts in_data this cycle.
REQ-007 out_n  output  32  signed rotation: +magnitude for 'R', -magnitude for 'L'.
REQ-008 out_valid  output  1  out_n holds a completed record.
REQ-009 out_ready  input  1  the downstream dial counter accepts out_n.
REQ-010 err  output  1  sticky flag: malformed or overflowed record seen.
REQ-011 rec_count  output  16  number of records emitted (handshaken) since reset.

Function
REQ-012 Input byte accept SHALL be in_valid & in_ready; output transfer SHALL be out_valid & out_ready.
REQ-013 States SHALL be DIR (expecting direction), DIGIT (accumulating magnitude) and EMIT (holding output).
REQ-014 in_ready SHALL be 1 in DIR and DIGIT and 0 in EMIT; out_valid SHALL be 1 only in EMIT.
REQ-015 DIR: 'L' (0x4C) SHALL set sign negative, clear magnitude and digit flag, and go to DIGIT; 'R' (0x52) SHALL do the same with sign positive.
REQ-016 DIR: CR (0x0D), LF (0x0A) and space (0x20) SHALL be discarded without error; any other byte SHALL set err and remain in DIR.
REQ-017 DIGIT: '0'-'9' SHALL update magnitude = magnitude*10 + digit, computed at 36 bits or wider, and set the digit flag.
REQ-018 If the updated magnitude exceeds 2147483647, the magnitude SHALL saturate at 2147483647, set err, and remain saturated for the rest of the record.
REQ-019 DIGIT: CR SHALL be discarded.
REQ-020 DIGIT: LF with the digit flag set SHALL register out_n (negated magnitude if sign negative) and enter EMIT on the next edge.
REQ-021 Output latency SHALL be one cycle: out_valid asserts in the cycle after the LF is accepted.
REQ-022 DIGIT: LF without any digit SHALL set err, drop the record and return to DIR.
REQ-023 DIGIT: any other byte SHALL set err, drop the record and return to DIR.
REQ-024 "L0" and "R0" SHALL both emit out_n = 0, with no negative-zero distinction.
REQ-025 EMIT: out_n SHALL remain stable while out_ready = 0; on transfer the block SHALL return to DIR and increment rec_count.
REQ-026 rec_count SHALL wrap from 65535 to 0.
REQ-027 No input byte SHALL be accepted in the transfer cycle; back-to-back records therefore need at least one cycle between emissions.
REQ-028 err SHALL never clear except by reset.

Reset
REQ-029 While reset_n = 0: state = DIR, out_n = 0, out_valid = 0, err = 0, rec_count = 0, magnitude = 0, and the sign and digit flags cleared.
REQ-030 in_ready SHALL be 0 while reset_n = 0 and 1 from the first edge after release.
REQ-031 Reset asserted mid-record or during EMIT SHALL discard the partial or pending record, with no emission and no rec_count increment.

Verification
REQ-032 "R48\n", out_ready = 1 -> single out_valid pulse with out_n = 48; rec_count = 1; err = 0.
REQ-033 "L68\r\n" -> out_n = -68 (0xFFFFFFBC); err = 0.
REQ-034 "L5\n" with out_ready = 0 for 3 cycles -> out_n = -5 held for 4 cycles, in_ready = 0 throughout, exactly one transfer, rec_count = 1.
REQ-035 "X" then "R7\n", and separately "R\n" -> err = 1; only out_n = 7 is emitted.
REQ-036 "R99999999999\n" -> out_n = 2147483647; err = 1.
REQ-037 "R12", then reset_n pulsed low, then "L3\n" -> only out_n = -3 is emitted; rec_count = 1; err = 0.
